// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle: three requester handshakes plus the registered register-file write port.
// The arbiter sits on the slave modport; requesters and the write port consumer sit on master.
interface wb_port_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              req0_valid_i;
    logic              req1_valid_i;
    logic              req2_valid_i;
    logic [REG_AW-1:0] req0_rd_i;
    logic [REG_AW-1:0] req1_rd_i;
    logic [REG_AW-1:0] req2_rd_i;
    logic [XLEN-1:0]   req0_data_i;
    logic [XLEN-1:0]   req1_data_i;
    logic [XLEN-1:0]   req2_data_i;
    logic              req0_ready_o;
    logic              req1_ready_o;
    logic              req2_ready_o;
    logic              W_we_o;
    logic [REG_AW-1:0] W_rd_o;
    logic [XLEN-1:0]   W_data_o;
    logic [1:0]        W_src_o;

    modport master (
        output req0_valid_i, req1_valid_i, req2_valid_i,
        output req0_rd_i, req1_rd_i, req2_rd_i,
        output req0_data_i, req1_data_i, req2_data_i,
        input  req0_ready_o, req1_ready_o, req2_ready_o,
        input  W_we_o, W_rd_o, W_data_o, W_src_o
    );

    modport slave (
        input  req0_valid_i, req1_valid_i, req2_valid_i,
        input  req0_rd_i, req1_rd_i, req2_rd_i,
        input  req0_data_i, req1_data_i, req2_data_i,
        output req0_ready_o, req1_ready_o, req2_ready_o,
        output W_we_o, W_rd_o, W_data_o, W_src_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: pipeline result has fixed priority, load and mul/div units share
// round-robin, and a long-latency unit that has waited STARVE_LIMIT cycles overrides the pipeline.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input logic                clk_i,
    input logic                rst_i,
    wb_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SRC_REQ0 = 2'd0,
        SRC_REQ1 = 2'd1,
        SRC_REQ2 = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

    logic          rr_ptr;   // 0: req1 preferred, 1: req2 preferred
    logic [CW-1:0] wait1;
    logic [CW-1:0] wait2;
    logic          starve1;
    logic          starve2;
    src_e          grant;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    assign starve1 = bus.req1_valid_i && (wait1 == LIMIT);
    assign starve2 = bus.req2_valid_i && (wait2 == LIMIT);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        grant = SRC_NONE;
        if (rst_i) begin
            grant = SRC_NONE;
        end else if (starve1 && starve2) begin
            grant = rr_ptr ? SRC_REQ2 : SRC_REQ1;
        end else if (starve1) begin
            grant = SRC_REQ1;
        end else if (starve2) begin
            grant = SRC_REQ2;
        end else if (bus.req0_valid_i) begin
            grant = SRC_REQ0;
        end else if (bus.req1_valid_i && bus.req2_valid_i) begin
            grant = rr_ptr ? SRC_REQ2 : SRC_REQ1;
        end else if (bus.req1_valid_i) begin
            grant = SRC_REQ1;
        end else if (bus.req2_valid_i) begin
            grant = SRC_REQ2;
        end
    end

    assign bus.req0_ready_o = (grant == SRC_REQ0);
    assign bus.req1_ready_o = (grant == SRC_REQ1);
    assign bus.req2_ready_o = (grant == SRC_REQ2);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        unique case (grant)
            SRC_REQ0: begin sel_rd = bus.req0_rd_i; sel_data = bus.req0_data_i; end
            SRC_REQ1: begin sel_rd = bus.req1_rd_i; sel_data = bus.req1_data_i; end
            SRC_REQ2: begin sel_rd = bus.req2_rd_i; sel_data = bus.req2_data_i; end
            default:  begin sel_rd = '0;            sel_data = '0;             end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr       <= 1'b0;
            wait1        <= '0;
            wait2        <= '0;
            bus.W_we_o   <= 1'b0;
            bus.W_rd_o   <= '0;
            bus.W_data_o <= '0;
            bus.W_src_o  <= SRC_NONE;
        end else begin
            if (grant == SRC_REQ1)      rr_ptr <= 1'b1;
            else if (grant == SRC_REQ2) rr_ptr <= 1'b0;

            if (!bus.req1_valid_i || grant == SRC_REQ1) wait1 <= '0;
            else if (wait1 != LIMIT)                    wait1 <= wait1 + CW'(1);

            if (!bus.req2_valid_i || grant == SRC_REQ2) wait2 <= '0;
            else if (wait2 != LIMIT)                    wait2 <= wait2 + CW'(1);

            // x0 writes are accepted and tagged with their source but never enable the write.
            bus.W_we_o  <= (grant != SRC_NONE) && (sel_rd != '0);
            bus.W_src_o <= grant;
            if (grant != SRC_NONE) begin
                bus.W_rd_o   <= sel_rd;
                bus.W_data_o <= sel_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, pipeline write, round-robin, starvation override,
// x0 write and reset during arbitration, with hand-computed expectations.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.XLEN(32), .REG_AW(5)) bus ();

    wb_port_arbiter #(.XLEN(32), .REG_AW(5), .STARVE_LIMIT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1, input logic r2);
        #1;
        check({tag, ".ready"}, {29'd0, bus.req0_ready_o, bus.req1_ready_o, bus.req2_ready_o},
              {29'd0, r0, r1, r2});
    endtask

    task automatic check_wp(input string tag, input logic we, input logic [1:0] src,
                            input logic [4:0] rd, input logic [31:0] data);
        check({tag, ".we"},   {31'd0, bus.W_we_o}, {31'd0, we});
        check({tag, ".src"},  {30'd0, bus.W_src_o}, {30'd0, src});
        check({tag, ".rd"},   {27'd0, bus.W_rd_o}, {27'd0, rd});
        check({tag, ".data"}, bus.W_data_o, data);
    endtask

    initial begin
        bus.req0_valid_i = 1'b1; bus.req0_rd_i = 5'd1; bus.req0_data_i = 32'h1;
        bus.req1_valid_i = 1'b1; bus.req1_rd_i = 5'd2; bus.req1_data_i = 32'h2;
        bus.req2_valid_i = 1'b1; bus.req2_rd_i = 5'd3; bus.req2_data_i = 32'h3;

        // Reset held two cycles with all valids high
        for (int i = 0; i < 2; i++) begin
            tick();
            check_ready("rst", 1'b0, 1'b0, 1'b0);
            check_wp("rst", 1'b0, 2'd3, 5'd0, 32'h0);
        end
        rst = 1'b0;
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0; bus.req2_valid_i = 1'b0;
        check_ready("idle", 1'b0, 1'b0, 1'b0);

        // Single pipeline write
        bus.req0_valid_i = 1'b1; bus.req0_rd_i = 5'd5; bus.req0_data_i = 32'h0000_1234;
        check_ready("p0", 1'b1, 1'b0, 1'b0);
        tick();
        bus.req0_valid_i = 1'b0;
        check_wp("p0.w", 1'b1, 2'd0, 5'd5, 32'h0000_1234);
        tick();
        check_wp("p0.idle", 1'b0, 2'd3, 5'd5, 32'h0000_1234);

        // Round-robin between req1 and req2, no bubbles
        bus.req1_valid_i = 1'b1; bus.req1_rd_i = 5'd3; bus.req1_data_i = 32'hA1;
        bus.req2_valid_i = 1'b1; bus.req2_rd_i = 5'd4; bus.req2_data_i = 32'hB2;
        check_ready("rr0", 1'b0, 1'b1, 1'b0);
        tick(); check_wp("rr1", 1'b1, 2'd1, 5'd3, 32'hA1); check_ready("rr1", 1'b0, 1'b0, 1'b1);
        tick(); check_wp("rr2", 1'b1, 2'd2, 5'd4, 32'hB2); check_ready("rr2", 1'b0, 1'b1, 1'b0);
        tick(); check_wp("rr3", 1'b1, 2'd1, 5'd3, 32'hA1); check_ready("rr3", 1'b0, 1'b0, 1'b1);
        tick(); check_wp("rr4", 1'b1, 2'd2, 5'd4, 32'hB2);
        bus.req1_valid_i = 1'b0; bus.req2_valid_i = 1'b0;
        tick(); check_wp("rr.idle", 1'b0, 2'd3, 5'd4, 32'hB2);

        // Starvation: req0 every cycle, req1 waits four cycles then overrides
        bus.req0_valid_i = 1'b1; bus.req0_rd_i = 5'd7; bus.req0_data_i = 32'h77;
        bus.req1_valid_i = 1'b1; bus.req1_rd_i = 5'd9; bus.req1_data_i = 32'h99;
        for (int c = 0; c < 4; c++) begin
            check_ready("stv.p0", 1'b1, 1'b0, 1'b0);
            tick();
            check_wp("stv.w0", 1'b1, 2'd0, 5'd7, 32'h77);
        end
        check_ready("stv.c4", 1'b0, 1'b1, 1'b0);
        tick();
        bus.req1_valid_i = 1'b0;
        check_wp("stv.w1", 1'b1, 2'd1, 5'd9, 32'h99);
        check("stv.wait1", {29'd0, dut.wait1}, 32'd0);
        check_ready("stv.c5", 1'b1, 1'b0, 1'b0);
        tick();
        bus.req0_valid_i = 1'b0;
        check_wp("stv.w5", 1'b1, 2'd0, 5'd7, 32'h77);

        // x0 write from req2: accepted, no write enable
        bus.req2_valid_i = 1'b1; bus.req2_rd_i = 5'd0; bus.req2_data_i = 32'hFFFF_FFFF;
        check_ready("x0", 1'b0, 1'b0, 1'b1);
        tick();
        bus.req2_valid_i = 1'b0;
        check_wp("x0.w", 1'b0, 2'd2, 5'd0, 32'hFFFF_FFFF);

        // Build rr_ptr=req2 and wait2=3, then reset mid-flight
        bus.req1_valid_i = 1'b1; bus.req1_rd_i = 5'd1; bus.req1_data_i = 32'h11;
        check_ready("mf.g1", 1'b0, 1'b1, 1'b0);
        tick();
        bus.req0_valid_i = 1'b1; bus.req0_rd_i = 5'd6; bus.req0_data_i = 32'h66;
        bus.req1_rd_i = 5'd3; bus.req1_data_i = 32'h33;
        bus.req2_valid_i = 1'b1; bus.req2_rd_i = 5'd4; bus.req2_data_i = 32'h44;
        for (int c = 0; c < 3; c++) begin
            check_ready("mf.p0", 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("mf.wait2", {29'd0, dut.wait2}, 32'd3);
        bus.req0_valid_i = 1'b0;
        rst = 1'b1;
        check_ready("mf.rst", 1'b0, 1'b0, 1'b0);
        tick();
        check_wp("mf.rst.w", 1'b0, 2'd3, 5'd0, 32'h0);
        rst = 1'b0;
        check("mf.wait1", {29'd0, dut.wait1}, 32'd0);
        check("mf.wait2z", {29'd0, dut.wait2}, 32'd0);
        check_ready("mf.rel", 1'b0, 1'b1, 1'b0);
        tick();
        bus.req1_valid_i = 1'b0;
        check_wp("mf.w1", 1'b1, 2'd1, 5'd3, 32'h33);
        check_ready("mf.g2", 1'b0, 1'b0, 1'b1);
        tick();
        bus.req2_valid_i = 1'b0;
        check_wp("mf.w2", 1'b1, 2'd2, 5'd4, 32'h44);
        tick();
        check_wp("mf.idle", 1'b0, 2'd3, 5'd4, 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
